// File: rtl/sram_scan_bridge.sv
// rtl/sram_scan_bridge.sv - bit-serial scan front end for a word SRAM (burst write / burst read)
// SRAM_SCAN_ECHO_EN: scan_out echoes scan_in by one register outside RSHIFT.
module sram_scan_bridge #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_in,
    output logic scan_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_ADR, S_WDATA, S_RLOAD, S_RSHIFT, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic           mode;
    logic [5:0]     bit_cnt;
    logic [31:0]    shreg;
    logic [31:0]    count;
    logic [AW-1:0]  addr;
    logic [31:0]    rdreg;
    logic [31:0]    mem [DEPTH];

    logic           last_bit;
    logic [31:0]    shift_next;
    logic [31:0]    rd_word;
    logic           mem_we;
    logic           pass_bit;

    assign last_bit   = (bit_cnt == 6'd31);
    assign shift_next = {scan_in, shreg[31:1]};
    assign rd_word    = mem[addr];
    assign mem_we     = !rst && (state == S_WDATA) && last_bit;

`ifdef SRAM_SCAN_ECHO_EN
    assign pass_bit = scan_in;
`else
    assign pass_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_CNT;
            S_CNT:    if (last_bit) state_nxt = S_ADR;
            S_ADR: begin
                if (last_bit) begin
                    if (count == 32'd0) state_nxt = S_DONE;
                    else if (mode)      state_nxt = S_WDATA;
                    else                state_nxt = S_RLOAD;
                end
            end
            S_WDATA:  if (last_bit && count == 32'd1) state_nxt = S_DONE;
            S_RLOAD:  state_nxt = S_RSHIFT;
            S_RSHIFT: if (last_bit && count == 32'd1) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // SRAM array has no reset; only control state is cleared
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= shift_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= 1'b0;
            bit_cnt  <= 6'd0;
            shreg    <= 32'd0;
            count    <= 32'd0;
            addr     <= '0;
            rdreg    <= 32'd0;
            scan_out <= 1'b0;
        end else begin
            scan_out <= pass_bit;
            case (state)
                S_IDLE: begin
                    mode    <= scan_in;
                    bit_cnt <= 6'd0;
                end
                S_CNT, S_ADR, S_WDATA: begin
                    shreg   <= shift_next;
                    bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                    if (last_bit) begin
                        if (state == S_CNT) count <= shift_next;
                        if (state == S_ADR) addr  <= shift_next[AW-1:0];
                        if (state == S_WDATA) begin
                            addr  <= addr + 1'b1;
                            count <= count - 32'd1;
                        end
                    end
                end
                S_RLOAD: begin
                    rdreg    <= rd_word;
                    scan_out <= rd_word[0];
                    addr     <= addr + 1'b1;
                    bit_cnt  <= 6'd0;
                end
                S_RSHIFT: begin
                    bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                    if (last_bit) begin
                        count <= count - 32'd1;
                        // next word loads on the same edge so the stream has no gap
                        if (count != 32'd1) begin
                            rdreg    <= rd_word;
                            scan_out <= rd_word[0];
                            addr     <= addr + 1'b1;
                        end
                    end else begin
                        rdreg    <= {1'b0, rdreg[31:1]};
                        scan_out <= rdreg[1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_scan_bridge.sv
// tb/tb_sram_scan_bridge.sv - scoreboard bench for sram_scan_bridge
module tb_sram_scan_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_in = 1'b0;
    logic scan_out;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

`ifdef SRAM_SCAN_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    sram_scan_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .scan_in  (scan_in),
        .scan_out (scan_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_in = 1'b0;
        step();
        step();
        check("reset_scan_out", {31'd0, scan_out}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        scan_in = b;
        step();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) send_bit(w[i]);
    endtask

    task automatic send_hdr(input logic m, input logic [31:0] cnt, input logic [31:0] adr);
        send_bit(m);
        send_word(cnt);
        send_word(adr);
        scan_in = 1'b0;
    endtask

    // header, then the RLOAD edge; each word is compared against the queue head
    task automatic read_words(input string tag, input logic [31:0] cnt, input logic [31:0] adr, input int n);
        logic [31:0] w;
        send_hdr(1'b0, cnt, adr);
        step();
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 32; j++) begin
                w[j] = scan_out;
                step();
            end
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                check(tag, w, exp_q.pop_front());
            end
        end
    endtask

    logic [31:0] prog [4] = '{32'h00012117, 32'h04010113, 32'h00022517, 32'h03c50513};
    logic [31:0] pat;

    initial begin
        do_reset();

        send_hdr(1'b1, 32'd4, 32'd0);
        for (int i = 0; i < 4; i++) send_word(prog[i]);
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(prog[i]);
        read_words("rd4", 32'd4, 32'd0, 4);
        check("done_out", {31'd0, scan_out}, 32'd0);
        step();
        check("done_out_hold", {31'd0, scan_out}, 32'd0);
        do_reset();

        for (int i = 0; i < 4; i++) exp_q.push_back(prog[i]);
        read_words("rd_max", 32'hFFFF_FFFF, 32'd0, 4);
        do_reset();

        send_hdr(1'b1, 32'd2, 32'd2047);
        send_word(32'hA5A5A5A5);
        send_word(32'h5A5A5A5A);
        do_reset();
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h5A5A5A5A);
        read_words("rd_wrap", 32'd2, 32'd2047, 2);
        do_reset();
        exp_q.push_back(32'h5A5A5A5A);
        read_words("rd_addr0", 32'd1, 32'd0, 1);
        do_reset();
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h5A5A5A5A);
        exp_q.push_back(prog[1]);
        read_words("rd_wrap_max", 32'hFFFF_FFFF, 32'd2047, 3);
        do_reset();

        // COUNT=0 write: trailing data must not reach memory
        send_hdr(1'b1, 32'd0, 32'd1);
        pat = 32'hFFFF_0F0F;
        for (int i = 0; i < 32; i++) begin
            send_bit(pat[i]);
            check("cnt0_out", {31'd0, scan_out}, ECHO ? {31'd0, pat[i]} : 32'd0);
        end
        do_reset();
        exp_q.push_back(prog[1]);
        read_words("cnt0_mem", 32'd1, 32'd1, 1);
        do_reset();

        // abort during the third word
        send_hdr(1'b1, 32'd3, 32'd0);
        send_word(32'h11111111);
        send_word(32'h22222222);
        pat = 32'h33333333;
        for (int i = 0; i < 20; i++) send_bit(pat[i]);
        do_reset();
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(prog[2]);
        read_words("abort", 32'd3, 32'd0, 3);
        do_reset();

        // echo during CNT
        send_bit(1'b0);
        pat = 32'hC3A5_96E1;
        for (int i = 0; i < 32; i++) begin
            send_bit(pat[i]);
            check("echo_cnt", {31'd0, scan_out}, ECHO ? {31'd0, pat[i]} : 32'd0);
        end
        do_reset();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
